// File: rtl/request_unit.sv
// Memory request sequencer: turns decoded load/store/halt intent into I/D memory enables and pc_en.
// Optional REQ_STALL_STATS_EN adds saturating instruction/data stall counters.
module request_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   cu_dREN,
    input  logic                   cu_dWEN,
    input  logic                   halt,
    output logic                   imemREN,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic                   pc_en,
    output logic                   halted
`ifdef REQ_STALL_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] istall_cnt,
    output logic [STALL_CNT_W-1:0] dstall_cnt
`endif
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_q;
    logic   dren_q;
    logic   dwen_q;

    logic   mem_op;
    assign mem_op = cu_dREN | cu_dWEN;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (ihit) begin
                        if (halt) begin
                            state_q <= HALTED;
                        end else if (mem_op) begin
                            // A store wins when the decoder flags both.
                            state_q <= DATA;
                            dwen_q  <= cu_dWEN;
                            dren_q  <= cu_dREN & ~cu_dWEN;
                        end
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state_q <= FETCH;
                        dren_q  <= 1'b0;
                        dwen_q  <= 1'b0;
                    end
                end
                default: state_q <= HALTED;
            endcase
        end
    end

    assign imemREN = (state_q == FETCH) || (state_q == DATA);
    assign dmemREN = (state_q == DATA) && dren_q;
    assign dmemWEN = (state_q == DATA) && dwen_q;
    assign halted  = (state_q == HALTED);

    // Same-cycle retire on ihit for non-memory instructions, on dhit for loads/stores.
    assign pc_en = !RST &&
                   (((state_q == FETCH) && ihit && !halt && !mem_op) ||
                    ((state_q == DATA) && dhit));

`ifdef REQ_STALL_STATS_EN
    logic [STALL_CNT_W-1:0] istall_q, istall_d;
    logic [STALL_CNT_W-1:0] dstall_q, dstall_d;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        istall_d = istall_q;
        dstall_d = dstall_q;
        if ((state_q == FETCH) && !ihit) istall_d = sat_inc(istall_q);
        if ((state_q == DATA) && !dhit)  dstall_d = sat_inc(dstall_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            istall_q <= '0;
            dstall_q <= '0;
        end else begin
            istall_q <= istall_d;
            dstall_q <= dstall_d;
        end
    end

    assign istall_cnt = istall_q;
    assign dstall_cnt = dstall_q;
`else
    generate
        if (STALL_CNT_W > 0) begin : g_stats_absent
        end
    endgenerate
`endif

endmodule
